// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared UART register map, status bits and loader state codes
//
// Purpose : constants shared by the RS232 poller and the UART frame loader.
// Ports   : none (package).
package rs232_pkg;

   localparam logic [4:0] UART_RX_ADDR     = 5'd0;
   localparam logic [4:0] UART_TX_ADDR     = 5'd4;
   localparam logic [4:0] UART_STATUS_ADDR = 5'd8;

   localparam int STATUS_RX_READY_BIT = 7;
   localparam int STATUS_TX_READY_BIT = 6;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_POLL_RX  = 3'd1;
   localparam logic [2:0] S_READ_RX  = 3'd2;
   localparam logic [2:0] S_FB_WRITE = 3'd3;
   localparam logic [2:0] S_POLL_TX  = 3'd4;
   localparam logic [2:0] S_SEND_ACK = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   // The UART TX register only looks at the low byte; upper bits stay zero.
   function automatic logic [31:0] tx_word(input logic [7:0] b);
      return {24'd0, b};
   endfunction

endpackage

// File: rtl/uart_avm_master.sv
// rtl/uart_avm_master.sv - single-outstanding Avalon-MM read/write handshake
//
// Purpose : turns a one-cycle request into an Avalon-MM transfer held until
//           waitrequest is low, then reports completion.
// Ports   : avm_clk, avm_rst (sync, active-low)
//           req/we/addr/wdata - request; sampled only when no transfer is
//                               pending or the pending one completes this cycle
//           done              - current transfer completes this cycle
//           rdata             - low byte of avm_readdata, valid with done
//           avm_*             - Avalon-MM master signals
module uart_avm_master
   import rs232_pkg::*;
(
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic        req,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [7:0]  wdata,
   output logic        done,
   output logic [7:0]  rdata,
   output logic [4:0]  avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   logic active;
   logic unused_rdata_hi;

   assign active          = avm_read | avm_write;
   assign done            = active & ~avm_waitrequest;
   assign rdata           = avm_readdata[7:0];
   assign unused_rdata_hi = ^avm_readdata[31:8];

   // A new request may follow a completing one on the very next edge, so
   // back-to-back status polls keep avm_read high without a gap.
   always_ff @(posedge avm_clk) begin
      if (!avm_rst) begin
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= UART_STATUS_ADDR;
         avm_writedata <= '0;
      end else if (!active || done) begin
         avm_read  <= req & ~we;
         avm_write <= req & we;
         if (req) begin
            avm_address <= addr;
            if (we) begin
               avm_writedata <= tx_word(wdata);
            end
         end
      end
   end

endmodule

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - loads a grey frame from a UART into a frame buffer
//
// Purpose : on start, polls the UART for IMG_W*IMG_H bytes, writes each into
//           the frame buffer, and sends ACK_BYTE every ACK_EVERY bytes and
//           after the final byte.
// Ports   : avm_clk, avm_rst (sync, active-low), start
//           avm_address/avm_read/avm_write/avm_writedata/avm_readdata/
//           avm_waitrequest - Avalon-MM master to the UART
//           fb_we/fb_addr/fb_data - frame-buffer write port
//           busy, frame_done - status
module uart_frame_loader
   import rs232_pkg::*;
#(
   parameter int         IMG_W     = 640,
   parameter int         IMG_H     = 480,
   parameter int         ACK_EVERY = 64,
   parameter logic [7:0] ACK_BYTE  = 8'h06
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic        start,
   output logic [4:0]  avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        fb_we,
   output logic [18:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        busy,
   output logic        frame_done
);

   localparam int              NPIX      = IMG_W * IMG_H;
   localparam logic [18:0]     LAST_PIX  = 19'(NPIX - 1);
   localparam int              ACK_W     = $clog2(ACK_EVERY + 1);
   localparam logic [ACK_W-1:0] ACK_LIMIT = ACK_W'(ACK_EVERY);

   state_t           state;
   logic [18:0]      pix_cnt;
   logic [ACK_W-1:0] ack_cnt;
   logic [ACK_W-1:0] ack_next;
   logic             last_pix;

   logic             mst_req;
   logic             mst_we;
   logic [4:0]       mst_addr;
   logic [7:0]       mst_wdata;
   logic             mst_done;
   logic [7:0]       mst_rdata;

   assign busy     = (state != S_IDLE);
   assign ack_next = ack_cnt + 1'b1;

   uart_avm_master u_master (
      .avm_clk         (avm_clk),
      .avm_rst         (avm_rst),
      .req             (mst_req),
      .we              (mst_we),
      .addr            (mst_addr),
      .wdata           (mst_wdata),
      .done            (mst_done),
      .rdata           (mst_rdata),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   // Next bus request is chosen in the cycle the current one completes, so
   // it is issued on the same edge the state changes.
   always_comb begin
      mst_req   = 1'b0;
      mst_we    = 1'b0;
      mst_addr  = UART_STATUS_ADDR;
      mst_wdata = ACK_BYTE;
      case (state)
         S_IDLE:     mst_req = start;
         S_POLL_RX: begin
            if (mst_done) begin
               mst_req = 1'b1;
               if (mst_rdata[STATUS_RX_READY_BIT]) begin
                  mst_addr = UART_RX_ADDR;
               end
            end
         end
         S_FB_WRITE: mst_req = 1'b1;
         S_POLL_TX: begin
            if (mst_done) begin
               mst_req = 1'b1;
               if (mst_rdata[STATUS_TX_READY_BIT]) begin
                  mst_we   = 1'b1;
                  mst_addr = UART_TX_ADDR;
               end
            end
         end
         S_SEND_ACK: mst_req = mst_done & ~last_pix;
         default:    mst_req = 1'b0;
      endcase
   end

   always_ff @(posedge avm_clk) begin
      if (!avm_rst) begin
         state      <= S_IDLE;
         pix_cnt    <= '0;
         ack_cnt    <= '0;
         last_pix   <= 1'b0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         frame_done <= 1'b0;
      end else begin
         fb_we      <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_POLL_RX;
                  pix_cnt  <= '0;
                  ack_cnt  <= '0;
                  last_pix <= 1'b0;
               end
            end
            S_POLL_RX: begin
               if (mst_done && mst_rdata[STATUS_RX_READY_BIT]) begin
                  state <= S_READ_RX;
               end
            end
            S_READ_RX: begin
               if (mst_done) begin
                  fb_we   <= 1'b1;
                  fb_addr <= pix_cnt;
                  fb_data <= mst_rdata;
                  state   <= S_FB_WRITE;
               end
            end
            S_FB_WRITE: begin
               pix_cnt  <= pix_cnt + 19'd1;
               ack_cnt  <= ack_next;
               last_pix <= (pix_cnt == LAST_PIX);
               if (ack_next == ACK_LIMIT || pix_cnt == LAST_PIX) begin
                  state <= S_POLL_TX;
               end else begin
                  state <= S_POLL_RX;
               end
            end
            S_POLL_TX: begin
               if (mst_done && mst_rdata[STATUS_TX_READY_BIT]) begin
                  state <= S_SEND_ACK;
               end
            end
            S_SEND_ACK: begin
               if (mst_done) begin
                  ack_cnt <= '0;
                  if (last_pix) begin
                     state      <= S_DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= S_POLL_RX;
                  end
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               pix_cnt <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - self-checking bench for uart_frame_loader
module tb_uart_frame_loader;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int AE   = 4;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        avm_rst;
   logic        start;
   logic [4:0]  avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [7:0]  fb_data;
   logic        busy;
   logic        frame_done;

   always #5 clk = ~clk;

   uart_frame_loader #(.IMG_W(W), .IMG_H(H), .ACK_EVERY(AE), .ACK_BYTE(8'h06)) dut (
      .avm_clk         (clk),
      .avm_rst         (avm_rst),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .fb_we           (fb_we),
      .fb_addr         (fb_addr),
      .fb_data         (fb_data),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   // ---------------- UART slave model ----------------
   int         cfg_wait, cfg_rx, cfg_tx;
   bit         cfg_rnd;
   bit         clr;
   logic [7:0] rx_data [NPIX];
   int         wait_left, rx_idx, rx_hold, tx_hold;

   assign avm_waitrequest = (avm_read | avm_write) && (wait_left != 0);

   always_comb begin
      avm_readdata = 32'h0;
      if (avm_address == 5'd8)
         avm_readdata = {24'h0, (rx_hold == 0 && rx_idx < NPIX), (tx_hold == 0), 6'b0};
      else if (avm_address == 5'd0)
         avm_readdata = {24'h5A5A5A, (rx_idx < NPIX) ? rx_data[rx_idx] : 8'hEE};
   end

   always @(posedge clk) begin
      if (!avm_rst || clr) begin
         wait_left <= cfg_wait;
         rx_idx    <= 0;
         rx_hold   <= cfg_rx;
         tx_hold   <= cfg_tx;
      end else if (avm_read || avm_write) begin
         if (wait_left == 0) begin
            wait_left <= cfg_rnd ? int'($urandom_range(0, cfg_wait)) : cfg_wait;
            if (avm_read && avm_address == 5'd8) begin
               if (rx_hold > 0) rx_hold <= rx_hold - 1;
               if (tx_hold > 0) tx_hold <= tx_hold - 1;
            end
            if (avm_read && avm_address == 5'd0) begin
               rx_idx  <= rx_idx + 1;
               rx_hold <= cfg_rnd ? int'($urandom_range(0, cfg_rx)) : cfg_rx;
               tx_hold <= cfg_rnd ? int'($urandom_range(0, cfg_tx)) : cfg_tx;
            end
         end else begin
            wait_left <= wait_left - 1;
         end
      end
   end

   // ---------------- bus / frame-buffer monitor ----------------
   int          mon_err, wr_cnt, ack_seen, done_cnt, rx_since_ack;
   logic [7:0]  fb_mem [NPIX];
   int          wcnt   [NPIX];
   bit          pend_fb, prev_stall, prev_rd, prev_wr;
   logic [4:0]  prev_addr;
   logic [31:0] prev_wdata;

   always @(negedge clk) begin
      if (clr) begin
         mon_err = 0; wr_cnt = 0; ack_seen = 0; done_cnt = 0; rx_since_ack = 0;
         pend_fb = 0; prev_stall = 0;
         for (int i = 0; i < NPIX; i++) begin
            fb_mem[i] = 8'h00;
            wcnt[i]   = 0;
         end
      end else if (!avm_rst) begin
         pend_fb    = 0;
         prev_stall = 0;
      end else begin
         if (avm_read && avm_write) mon_err++;
         if (prev_stall && (avm_read != prev_rd || avm_write != prev_wr ||
             avm_address != prev_addr || (avm_write && avm_writedata != prev_wdata)))
            mon_err++;
         if (fb_we != pend_fb) mon_err++;
         pend_fb = 0;
         if (fb_we) begin
            wr_cnt++;
            if (fb_addr >= 19'(NPIX)) mon_err++;
            else begin
               if (wcnt[fb_addr] != 0) mon_err++;
               wcnt[fb_addr]++;
               fb_mem[fb_addr] = fb_data;
            end
         end
         if (avm_read && !avm_waitrequest && avm_address == 5'd0) begin
            pend_fb = 1;
            if (rx_since_ack >= AE) mon_err++;
            rx_since_ack++;
         end
         if (avm_write && !avm_waitrequest) begin
            if (avm_address != 5'd4 || avm_writedata != 32'h06) mon_err++;
            ack_seen++;
            rx_since_ack = 0;
         end
         if (frame_done) done_cnt++;
         if (!busy && (avm_read || avm_write)) mon_err++;
         prev_stall = (avm_read || avm_write) && avm_waitrequest;
         prev_rd    = avm_read;
         prev_wr    = avm_write;
         prev_addr  = avm_address;
         prev_wdata = avm_writedata;
      end
   end

   // ---------------- checking helpers ----------------
   int         n_pass, n_total;
   logic [7:0] exp_fb [NPIX];

   typedef struct {
      int         rx_polls;
      int         waits;
      int         tx_polls;
      logic [7:0] base;
      int         exp_writes;
      int         exp_acks;
      int         exp_done;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic setup(input int rxp, input int wt, input int txp, input bit rnd);
      cfg_rx = rxp; cfg_wait = wt; cfg_tx = txp; cfg_rnd = rnd;
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic start_frame();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         step();
         if (done_cnt > 0) ok = 1;
      end
      repeat (5) step();
   endtask

   task automatic check_frame(input string tag, input bit ok, input int ew, input int ea, input int ed);
      check({tag, " finished"}, ok, 1);
      check({tag, " fb writes"}, wr_cnt, ew);
      check({tag, " acks"}, ack_seen, ea);
      check({tag, " frame_done"}, done_cnt, ed);
      check({tag, " bus protocol"}, mon_err, 0);
      check({tag, " busy after"}, busy, 0);
      for (int i = 0; i < NPIX; i++)
         check($sformatf("%s pixel %0d", tag, i), fb_mem[i], exp_fb[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " avm_read"}, avm_read, 0);
      check({tag, " avm_write"}, avm_write, 0);
      check({tag, " avm_address"}, avm_address, 8);
      check({tag, " avm_writedata"}, avm_writedata, 0);
      check({tag, " fb_we"}, fb_we, 0);
      check({tag, " fb_addr"}, fb_addr, 0);
      check({tag, " fb_data"}, fb_data, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " frame_done"}, frame_done, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit ok;
      int exp_acks;
      n_pass = 0; n_total = 0;
      avm_rst = 1'b0; start = 1'b0; clr = 1'b0;
      cfg_wait = 0; cfg_rx = 0; cfg_tx = 0; cfg_rnd = 0;
      for (int i = 0; i < NPIX; i++) rx_data[i] = 8'h00;

      vecs[0] = '{0,  0, 0,  8'h10, 8, 2, 1};
      vecs[1] = '{20, 0, 0,  8'h10, 8, 2, 1};
      vecs[2] = '{0,  3, 0,  8'h10, 8, 2, 1};
      vecs[3] = '{0,  0, 10, 8'h10, 8, 2, 1};
      vecs[4] = '{2,  2, 5,  8'hF8, 8, 2, 1};

      setup(0, 0, 0, 0);
      repeat (3) step();
      check_reset_outputs("reset");
      avm_rst = 1'b1;
      step();

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < NPIX; i++) begin
            rx_data[i] = vecs[v].base + 8'(i);
            exp_fb[i]  = vecs[v].base + 8'(i);
         end
         setup(vecs[v].rx_polls, vecs[v].waits, vecs[v].tx_polls, 0);
         start_frame();
         wait_done(ok);
         check_frame($sformatf("vec%0d", v), ok, vecs[v].exp_writes, vecs[v].exp_acks, vecs[v].exp_done);
      end

      for (int r = 0; r < 4; r++) begin
         exp_acks = 0;
         for (int i = 0; i < NPIX; i++) begin
            rx_data[i] = 8'($urandom);
            exp_fb[i]  = rx_data[i];
            if ((i + 1) % AE == 0 || i == NPIX - 1) exp_acks++;
         end
         setup(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1);
         start_frame();
         wait_done(ok);
         check_frame($sformatf("rand%0d", r), ok, NPIX, exp_acks, 1);
      end

      // start pulsed mid-frame must not restart the load
      for (int i = 0; i < NPIX; i++) begin
         rx_data[i] = 8'h30 + 8'(i);
         exp_fb[i]  = rx_data[i];
      end
      setup(2, 1, 3, 0);
      start_frame();
      repeat (15) step();
      check("busy mid-frame", busy, 1);
      start_frame();
      wait_done(ok);
      repeat (60) step();
      check_frame("restart", ok, NPIX, 2, 1);

      // reset right after the third pixel, then a clean frame from address 0
      for (int i = 0; i < NPIX; i++) rx_data[i] = 8'h40 + 8'(i);
      setup(0, 1, 0, 0);
      start_frame();
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         step();
         if (wr_cnt == 3) ok = 1;
      end
      check("reached pixel 3", ok, 1);
      avm_rst = 1'b0;
      step();
      check_reset_outputs("midreset");
      step();
      check("no pixel after reset", wr_cnt, 3);
      avm_rst = 1'b1;
      for (int i = 0; i < NPIX; i++) begin
         rx_data[i] = 8'h50 + 8'(i);
         exp_fb[i]  = rx_data[i];
      end
      setup(0, 0, 0, 0);
      start_frame();
      wait_done(ok);
      check_frame("after reset", ok, NPIX, 2, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have parameter ACK_EVERY, default 64, RX bytes per TX acknowledge.
REQ-004 SHALL have parameter ACK_BYTE, default 8'h06, byte sent as acknowledge.
REQ-005 SHALL have port avm_clk  in  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port avm_rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a frame load.
REQ-008 SHALL have port avm_address  out  5  UART register byte address.
REQ-009 SHALL have port avm_read  out  1  Avalon-MM read request.
REQ-010 SHALL have port avm_write  out  1  Avalon-MM write request.
REQ-011 SHALL have port avm_writedata  out  32  TX data; bits [7:0] carry the byte, [31:8] zero.
REQ-012 SHALL have port avm_readdata  in  32  read data, valid in the cycle avm_waitrequest is low.
REQ-013 SHALL have port avm_waitrequest  in  1  slave stall.
REQ-014 SHALL have port fb_we  out  1  frame-buffer write strobe, one cycle per pixel.
REQ-015 SHALL have port fb_addr  out  19  linear pixel address, y*IMG_W+x.
REQ-016 SHALL have port fb_data  out  8  grey pixel value.
REQ-017 SHALL have port busy  out  1  high in every state except S_IDLE.
REQ-018 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel is acknowledged.

Function
REQ-019 SHALL use UART register map: RX 0, TX 4, STATUS 8; STATUS bit 7 = RX ready, bit 6 = TX ready.
REQ-020 SHALL hold avm_read/avm_write and avm_address stable until a cycle with avm_waitrequest low; that cycle completes the transfer, and the request drops or is replaced on the next edge.
REQ-021 SHALL never assert avm_read and avm_write together.
REQ-022 SHALL implement states S_IDLE, S_POLL_RX, S_READ_RX, S_FB_WRITE, S_POLL_TX, S_SEND_ACK, S_DONE.
REQ-023 S_IDLE: start=1 -> S_POLL_RX with read of STATUS; pixel and ack counters cleared; start ignored in all other states.
REQ-024 S_POLL_RX: completed read with bit 7=1 -> S_READ_RX (read RX); bit 7=0 -> repeat STATUS read.
REQ-025 S_READ_RX: on completion, latch avm_readdata[7:0] -> S_FB_WRITE.
REQ-026 S_FB_WRITE: exactly one cycle with fb_we=1, fb_addr=pixel count, fb_data=latched byte; pixel count +1, ack count +1.
REQ-027 After S_FB_WRITE: ack count==ACK_EVERY or last pixel (IMG_W*IMG_H-1) -> S_POLL_TX, else -> S_POLL_RX.
REQ-028 S_POLL_TX: STATUS read, bit 6=1 -> S_SEND_ACK, else repeat.
REQ-029 S_SEND_ACK: write ACK_BYTE to TX; on completion ack count cleared; last pixel -> S_DONE, else -> S_POLL_RX.
REQ-030 S_DONE: frame_done=1 for one cycle -> S_IDLE; pixel count wraps to 0.
REQ-031 Latency: fb_we asserted exactly one cycle after the RX read completes.
REQ-032 fb_we, frame_done registered outputs; fb_addr/fb_data hold last value outside S_FB_WRITE.

Reset
REQ-033 On avm_rst=0 at a clock edge: state S_IDLE, avm_read=0, avm_write=0, avm_address=8, avm_writedata=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, all counters 0.
REQ-034 Reset mid-transfer SHALL abandon the transfer immediately, no partial pixel written.

Structure
REQ-035 Register offsets, status bit indices and state enum SHALL live in shared package rs232_pkg, reused by the existing RS232 poller.
REQ-036 One sub-module uart_avm_master SHALL encapsulate the read/write-until-not-waitrequest handshake, exposing req/we/addr/wdata/done/rdata.

Verification (bench params IMG_W=4, IMG_H=2, ACK_EVERY=4)
REQ-037 Reset then start, UART model supplies bytes 0x10..0x17 -> fb writes addr 0..7 data 0x10..0x17, two TX writes of 0x06, one frame_done.
REQ-038 STATUS bit 7 low for 20 polls before each byte -> no fb_we during polling, same final buffer contents.
REQ-039 avm_waitrequest high 3 cycles on every access -> address/read/write stable throughout, each byte written exactly once.
REQ-040 TX-ready low for 10 polls at ack point -> no RX read until ACK written; fb_addr continues at 4.
REQ-041 start pulsed while busy -> ignored; reset asserted after 3rd pixel -> all outputs reset values, next start writes from addr 0.
